stream_stats_filter: RTL and testbench
======================================

Name: stream_stats_filter

Overview:
- Parametrised successor to the single-channel 8-bit running max/min/average processor.
- Tracks the running maximum and minimum of a signed sample stream and keeps a DEPTH-tap sample history.
- Each cycle it outputs one of: min/max midpoint, delayed sample, two-point average, DEPTH-point moving average, saturated first difference, or the last enabled sample.
- Adds a synchronous clear, exact (non-wrapping) arithmetic and an output-valid qualifier.

Parameters:
- WIDTH, 8: sample width in bits, signed two's complement, range 4..32.
- DEPTH, 4: number of history taps, power of two, range 2..16.
- LOG2D, 2: log2(DEPTH); must match DEPTH.

Ports:
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- SYNC_CLR  in  1  synchronous re-initialise request.
- RESTART  in  1  selects the midpoint output.
- ENABLE  in  1  selects the processed output and captures RLAST.
- MODE  in  2  selects the processing mode when ENABLE=1.
- DATA_IN  in  WIDTH  signed input sample.
- DATA_OUT  out  WIDTH  signed registered result.
- OUT_VALID  out  1  DATA_OUT is qualified.
- RMAX_OUT  out  WIDTH  current running maximum.
- RMIN_OUT  out  WIDTH  current running minimum.

Behaviour:
- Reset (RESET=0, asynchronous, no clock edge needed):
  - State S_INIT.
  - DATA_OUT=0, OUT_VALID=0, RMAX=RMIN=0, RLAST=0, all H[k]=0, FILL=0.
  - Reset asserted mid-operation aborts immediately to these values.
- FSM, all transitions on the rising CLOCK edge:
  - S_INIT -> S_LOAD unconditionally.
  - S_LOAD:
    - RMAX<=DATA_IN, RMIN<=DATA_IN.
    - H cleared, RLAST<=0, FILL<=0, DATA_OUT<=0, OUT_VALID<=0.
    - Then -> S_RUN.
  - S_RUN:
    - Stays in S_RUN.
    - SYNC_CLR=1 overrides everything: -> S_LOAD, no other register changes that edge.
- S_RUN output selection, priority order. All operands are pre-edge register values; DATA_IN is the current input.
  1. RESTART=1: DATA_OUT <= (RMAX+RMIN)/2.
     - Computed in WIDTH+1 bits, truncated toward zero; never wraps.
     - OUT_VALID<=1.
  2. ENABLE=1, by MODE:
     - 00: DATA_OUT <= H[DEPTH-1], i.e. DATA_IN delayed DEPTH run cycles.
     - 01: DATA_OUT <= (DATA_IN+H[DEPTH-1])/2, computed in WIDTH+1 bits, truncated toward zero.
     - 10: DATA_OUT <= (sum H[0..DEPTH-1]) >>> LOG2D.
       - Sum held in WIDTH+LOG2D bits.
       - Arithmetic shift, i.e. floor.
     - 11: DATA_OUT <= DATA_IN - H[0].
       - Computed in WIDTH+1 bits.
       - Saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
     - OUT_VALID <= (FILL==DEPTH).
  3. Otherwise: DATA_OUT <= RLAST (pre-edge), OUT_VALID<=1.
- RLAST <= DATA_IN whenever ENABLE=1 in S_RUN, regardless of RESTART.
  - With ENABLE=0, RLAST holds its value.
- Extremes, every S_RUN edge:
  - If DATA_IN > RMAX, then RMAX<=DATA_IN.
  - Else if DATA_IN < RMIN, then RMIN<=DATA_IN.
  - The midpoint in (1) uses the pre-update extremes.
- History shifts on every S_RUN edge, independent of ENABLE/RESTART: H[0]<=DATA_IN, H[k]<=H[k-1].
- FILL increments on each S_RUN shift and saturates at DEPTH.
- RMAX_OUT and RMIN_OUT are direct register outputs.
- Latency: 1 cycle from input sample to DATA_OUT for all paths.
- First S_RUN edge is at the 3rd rising edge after reset release.

Test Plan:
- Reset and init (WIDTH=8, DEPTH=4), release RESET with DATA_IN=5:
  - Edge 1 -> S_INIT->S_LOAD.
  - Edge 2 -> RMAX_OUT=RMIN_OUT=5, DATA_OUT=0, OUT_VALID=0.
- Moving average, MODE=10, ENABLE=1, DATA_IN 4,8,12,16,0 on successive run edges:
  - OUT_VALID=0 on the first 4 edges.
  - 5th edge -> DATA_OUT=10, OUT_VALID=1.
  - History -3,-3,-3,-2 -> DATA_OUT=-3 (floor).
- Midpoint, RESTART=1:
  - RMAX=127, RMIN=127 -> DATA_OUT=127 (no wrap).
  - RMAX=-127, RMIN=-128 -> DATA_OUT=-127 (toward zero).
  - RESTART and ENABLE both 1 -> midpoint output, RLAST still updated.
- Two-point and difference:
  - MODE=01, DATA_IN=-3, H[3]=0 -> DATA_OUT=-1.
  - MODE=11, DATA_IN=127, H[0]=-128 -> DATA_OUT=127.
  - MODE=11, DATA_IN=-128, H[0]=127 -> DATA_OUT=-128.
- Hold and extremes:
  - ENABLE=1 with DATA_IN=42, then ENABLE=0 with DATA_IN=-7 -> second output 42, then 42 again.
  - RMIN_OUT becomes -7 if -7 < RMIN.
- Clears:
  - SYNC_CLR=1 in S_RUN -> next edge S_LOAD, following edge RMAX/RMIN=DATA_IN, OUT_VALID=0, FILL=0.
  - RESET=0 asserted between edges mid-run -> DATA_OUT=0, OUT_VALID=0 immediately with no clock edge.

Source files
------------

// File: rtl/stream_stats_filter_if.sv
// Sample-stream bus for stream_stats_filter.
// The stream has no backpressure: the producer presents one sample per
// clock on DATA_IN and the block produces one registered result per clock.
// OUT_VALID qualifies DATA_OUT only; there is no ready signal and a result
// is never held waiting for a consumer.
interface stream_stats_filter_if #(
    parameter int WIDTH = 8
);
    logic                    SYNC_CLR;
    logic                    RESTART;
    logic                    ENABLE;
    logic [1:0]              MODE;
    logic signed [WIDTH-1:0] DATA_IN;
    logic signed [WIDTH-1:0] DATA_OUT;
    logic                    OUT_VALID;
    logic signed [WIDTH-1:0] RMAX_OUT;
    logic signed [WIDTH-1:0] RMIN_OUT;

    // Sample source / result sink side
    modport master (
        output SYNC_CLR, RESTART, ENABLE, MODE, DATA_IN,
        input  DATA_OUT, OUT_VALID, RMAX_OUT, RMIN_OUT
    );

    // Filter side
    modport slave (
        input  SYNC_CLR, RESTART, ENABLE, MODE, DATA_IN,
        output DATA_OUT, OUT_VALID, RMAX_OUT, RMIN_OUT
    );
endinterface

// File: rtl/stream_stats_filter.sv
// Running max/min tracker with a DEPTH-tap sample history.
// Every run cycle produces one of: min/max midpoint, delayed sample,
// two-point average, DEPTH-point moving average, saturated first
// difference, or the last enabled sample. All arithmetic is carried in
// widened precision so results never wrap.
module stream_stats_filter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LOG2D = 2
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    stream_stats_filter_if.slave  bus,
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam int SW = WIDTH + LOG2D;
    localparam logic [LOG2D:0] FILL_MAX = (LOG2D + 1)'(DEPTH);
    localparam logic [LOG2D:0] FILL_ONE = (LOG2D + 1)'(1);
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] data_out_q, data_out_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] rmax_q, rmax_d;
    logic signed [WIDTH-1:0] rmin_q, rmin_d;
    logic signed [WIDTH-1:0] rlast_q, rlast_d;
    logic [LOG2D:0]          fill_q, fill_d;
    logic signed [WIDTH-1:0] hist_q [DEPTH];
    logic signed [WIDTH-1:0] hist_d [DEPTH];

    logic signed [WIDTH:0]   mid_sum, mid_adj;
    logic signed [WIDTH:0]   pair_sum, pair_adj;
    logic signed [SW-1:0]    hist_sum;
    logic signed [WIDTH:0]   diff;
    logic signed [WIDTH-1:0] mid_res, pair_res, avg_res, diff_res;
    logic                    unused_bits;

    // Datapath candidates, all from pre-edge register values and DATA_IN.
    // Halving adds the sign bit before the shift so it truncates toward
    // zero; the moving average uses a plain arithmetic shift (floor).
    always_comb begin
        mid_sum  = {rmax_q[WIDTH-1], rmax_q} + {rmin_q[WIDTH-1], rmin_q};
        mid_adj  = mid_sum + {{WIDTH{1'b0}}, mid_sum[WIDTH]};
        mid_res  = mid_adj[WIDTH:1];

        pair_sum = {bus.DATA_IN[WIDTH-1], bus.DATA_IN}
                 + {hist_q[DEPTH-1][WIDTH-1], hist_q[DEPTH-1]};
        pair_adj = pair_sum + {{WIDTH{1'b0}}, pair_sum[WIDTH]};
        pair_res = pair_adj[WIDTH:1];

        hist_sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hist_sum = hist_sum + {{LOG2D{hist_q[k][WIDTH-1]}}, hist_q[k]};
        end
        avg_res  = hist_sum[SW-1:LOG2D];

        diff = {bus.DATA_IN[WIDTH-1], bus.DATA_IN} - {hist_q[0][WIDTH-1], hist_q[0]};
        if (diff[WIDTH] != diff[WIDTH-1]) begin
            diff_res = diff[WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            diff_res = diff[WIDTH-1:0];
        end

        unused_bits = ^{mid_adj[0], pair_adj[0], hist_sum[LOG2D-1:0]};
    end

    // Next-state and register update logic for the whole block
    always_comb begin
        state_d     = state_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        rmax_d      = rmax_q;
        rmin_d      = rmin_q;
        rlast_d     = rlast_q;
        fill_d      = fill_q;
        hist_d      = hist_q;

        case (state_q)
            S_INIT: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                rmax_d      = bus.DATA_IN;
                rmin_d      = bus.DATA_IN;
                rlast_d     = '0;
                fill_d      = '0;
                data_out_d  = '0;
                out_valid_d = 1'b0;
                for (int k = 0; k < DEPTH; k++) hist_d[k] = '0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (bus.SYNC_CLR) begin
                    // Clear wins outright: nothing else moves this edge
                    state_d = S_LOAD;
                end else begin
                    if (bus.RESTART) begin
                        data_out_d  = mid_res;
                        out_valid_d = 1'b1;
                    end else if (bus.ENABLE) begin
                        case (bus.MODE)
                            2'b00:   data_out_d = hist_q[DEPTH-1];
                            2'b01:   data_out_d = pair_res;
                            2'b10:   data_out_d = avg_res;
                            default: data_out_d = diff_res;
                        endcase
                        out_valid_d = (fill_q == FILL_MAX);
                    end else begin
                        data_out_d  = rlast_q;
                        out_valid_d = 1'b1;
                    end

                    if (bus.ENABLE) rlast_d = bus.DATA_IN;

                    if (bus.DATA_IN > rmax_q) begin
                        rmax_d = bus.DATA_IN;
                    end else if (bus.DATA_IN < rmin_q) begin
                        rmin_d = bus.DATA_IN;
                    end

                    hist_d[0] = bus.DATA_IN;
                    for (int k = 1; k < DEPTH; k++) hist_d[k] = hist_q[k-1];

                    if (fill_q != FILL_MAX) fill_d = fill_q + FILL_ONE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_INIT;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            rmax_q      <= '0;
            rmin_q      <= '0;
            rlast_q     <= '0;
            fill_q      <= '0;
            for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            rmax_q      <= rmax_d;
            rmin_q      <= rmin_d;
            rlast_q     <= rlast_d;
            fill_q      <= fill_d;
            for (int k = 0; k < DEPTH; k++) hist_q[k] <= hist_d[k];
        end
    end

    assign bus.DATA_OUT  = data_out_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.RMAX_OUT  = rmax_q;
    assign bus.RMIN_OUT  = rmin_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_stream_stats_filter.sv
// Directed bench for stream_stats_filter at WIDTH=8, DEPTH=4.
module tb_stream_stats_filter;
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         n_pass;
    int         n_total;

    stream_stats_filter_if #(.WIDTH(8)) bus_if ();

    stream_stats_filter #(.WIDTH(8), .DEPTH(4), .LOG2D(2)) dut (
        .CLOCK     (clk),
        .RESET     (rst_n),
        .bus       (bus_if),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rs, input logic en, input logic [1:0] md,
                          input logic signed [7:0] din);
        bus_if.RESTART = rs;
        bus_if.ENABLE  = en;
        bus_if.MODE    = md;
        bus_if.DATA_IN = din;
    endtask

    // Reset, then step through INIT and LOAD so the next edge is a run edge
    task automatic init_run(input logic signed [7:0] din);
        bus_if.SYNC_CLR = 1'b0;
        set_in(1'b0, 1'b0, 2'b00, din);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tick;
    endtask

    task automatic test_reset;
        bus_if.SYNC_CLR = 1'b0;
        set_in(1'b0, 1'b0, 2'b00, 8'sd5);
        rst_n = 1'b0;
        #12;
        n_total++; if (bus_if.DATA_OUT !== 8'sd0) $display("FAIL rst_data_out got=%0d exp=0", bus_if.DATA_OUT); else n_pass++;
        n_total++; if (bus_if.OUT_VALID !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", bus_if.OUT_VALID); else n_pass++;
        n_total++; if (bus_if.RMAX_OUT !== 8'sd0 || bus_if.RMIN_OUT !== 8'sd0) $display("FAIL rst_extremes got=%0d/%0d exp=0/0", bus_if.RMAX_OUT, bus_if.RMIN_OUT); else n_pass++;
        n_total++; if (state_dbg !== 2'd0) $display("FAIL rst_state got=%0d exp=0", state_dbg); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        n_total++; if (state_dbg !== 2'd1) $display("FAIL init_to_load got=%0d exp=1", state_dbg); else n_pass++;
        tick;
        n_total++; if (bus_if.RMAX_OUT !== 8'sd5 || bus_if.RMIN_OUT !== 8'sd5) $display("FAIL load_extremes got=%0d/%0d exp=5/5", bus_if.RMAX_OUT, bus_if.RMIN_OUT); else n_pass++;
        n_total++; if (bus_if.DATA_OUT !== 8'sd0 || bus_if.OUT_VALID !== 1'b0) $display("FAIL load_out got=%0d/%0b exp=0/0", bus_if.DATA_OUT, bus_if.OUT_VALID); else n_pass++;
        n_total++; if (state_dbg !== 2'd2) $display("FAIL load_to_run got=%0d exp=2", state_dbg); else n_pass++;
    endtask

    task automatic test_delay;
        logic signed [7:0] exp_d;
        init_run(8'sd0);
        for (int i = 1; i <= 8; i++) begin
            set_in(1'b0, 1'b1, 2'b00, 8'(i * 3));
            tick;
            exp_d = (i <= 4) ? 8'sd0 : 8'((i - 4) * 3);
            n_total++; if (bus_if.DATA_OUT !== exp_d) $display("FAIL delay_%0d got=%0d exp=%0d", i, bus_if.DATA_OUT, exp_d); else n_pass++;
            n_total++; if (bus_if.OUT_VALID !== (i > 4)) $display("FAIL delay_valid_%0d got=%0b exp=%0b", i, bus_if.OUT_VALID, (i > 4)); else n_pass++;
        end
    endtask

    task automatic test_moving_avg;
        logic signed [7:0] ins [5];
        logic signed [7:0] exps [5];
        ins  = '{8'sd4, 8'sd8, 8'sd12, 8'sd16, 8'sd0};
        exps = '{8'sd0, 8'sd1, 8'sd3, 8'sd6, 8'sd10};
        init_run(8'sd0);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 2'b10, ins[i]);
            tick;
            n_total++; if (bus_if.DATA_OUT !== exps[i]) $display("FAIL mavg_%0d got=%0d exp=%0d", i, bus_if.DATA_OUT, exps[i]); else n_pass++;
            n_total++; if (bus_if.OUT_VALID !== (i == 4)) $display("FAIL mavg_valid_%0d got=%0b exp=%0b", i, bus_if.OUT_VALID, (i == 4)); else n_pass++;
        end
        // History becomes -2,-3,-3,-3 (newest first): sum -11, floor(/4) = -3
        set_in(1'b0, 1'b1, 2'b10, -8'sd3); tick;
        set_in(1'b0, 1'b1, 2'b10, -8'sd3); tick;
        set_in(1'b0, 1'b1, 2'b10, -8'sd3); tick;
        set_in(1'b0, 1'b1, 2'b10, -8'sd2); tick;
        set_in(1'b0, 1'b1, 2'b10, 8'sd0);  tick;
        n_total++; if (bus_if.DATA_OUT !== -8'sd3) $display("FAIL mavg_floor got=%0d exp=-3", bus_if.DATA_OUT); else n_pass++;
    endtask

    task automatic test_midpoint;
        init_run(8'sd127);
        set_in(1'b1, 1'b0, 2'b00, 8'sd127);
        tick;
        n_total++; if (bus_if.DATA_OUT !== 8'sd127 || bus_if.OUT_VALID !== 1'b1) $display("FAIL mid_nowrap got=%0d/%0b exp=127/1", bus_if.DATA_OUT, bus_if.OUT_VALID); else n_pass++;

        init_run(8'h80);
        set_in(1'b0, 1'b0, 2'b00, -8'sd127);
        tick;
        n_total++; if (bus_if.RMAX_OUT !== -8'sd127 || bus_if.RMIN_OUT !== 8'h80) $display("FAIL mid_extremes got=%0d/%0d exp=-127/-128", bus_if.RMAX_OUT, bus_if.RMIN_OUT); else n_pass++;
        set_in(1'b1, 1'b0, 2'b00, 8'h80);
        tick;
        n_total++; if (bus_if.DATA_OUT !== -8'sd127) $display("FAIL mid_trunc got=%0d exp=-127", bus_if.DATA_OUT); else n_pass++;
        // RESTART beats ENABLE; midpoint uses the pre-edge extremes
        set_in(1'b1, 1'b1, 2'b00, 8'sd55);
        tick;
        n_total++; if (bus_if.DATA_OUT !== -8'sd127) $display("FAIL mid_priority got=%0d exp=-127", bus_if.DATA_OUT); else n_pass++;
        n_total++; if (bus_if.RMAX_OUT !== 8'sd55) $display("FAIL mid_rmax_upd got=%0d exp=55", bus_if.RMAX_OUT); else n_pass++;
        set_in(1'b0, 1'b0, 2'b00, 8'sd0);
        tick;
        n_total++; if (bus_if.DATA_OUT !== 8'sd55) $display("FAIL mid_rlast got=%0d exp=55", bus_if.DATA_OUT); else n_pass++;
    endtask

    task automatic test_two_point_diff;
        init_run(8'sd0);
        set_in(1'b0, 1'b1, 2'b01, -8'sd3);
        tick;
        n_total++; if (bus_if.DATA_OUT !== -8'sd1) $display("FAIL pair_trunc got=%0d exp=-1", bus_if.DATA_OUT); else n_pass++;
        n_total++; if (bus_if.OUT_VALID !== 1'b0) $display("FAIL pair_valid got=%0b exp=0", bus_if.OUT_VALID); else n_pass++;
        set_in(1'b0, 1'b0, 2'b00, 8'h80);
        tick;
        n_total++; if (bus_if.DATA_OUT !== -8'sd3) $display("FAIL pair_hold got=%0d exp=-3", bus_if.DATA_OUT); else n_pass++;
        set_in(1'b0, 1'b1, 2'b11, 8'sd127);
        tick;
        n_total++; if (bus_if.DATA_OUT !== 8'sd127) $display("FAIL diff_sat_hi got=%0d exp=127", bus_if.DATA_OUT); else n_pass++;
        set_in(1'b0, 1'b1, 2'b11, 8'h80);
        tick;
        n_total++; if (bus_if.DATA_OUT !== 8'h80) $display("FAIL diff_sat_lo got=%0d exp=-128", bus_if.DATA_OUT); else n_pass++;
        set_in(1'b0, 1'b1, 2'b11, -8'sd100);
        tick;
        n_total++; if (bus_if.DATA_OUT !== 8'sd28) $display("FAIL diff_plain got=%0d exp=28", bus_if.DATA_OUT); else n_pass++;
    endtask

    task automatic test_hold;
        init_run(8'sd0);
        set_in(1'b0, 1'b1, 2'b00, 8'sd42);
        tick;
        set_in(1'b0, 1'b0, 2'b00, -8'sd7);
        tick;
        n_total++; if (bus_if.DATA_OUT !== 8'sd42 || bus_if.OUT_VALID !== 1'b1) $display("FAIL hold_1 got=%0d/%0b exp=42/1", bus_if.DATA_OUT, bus_if.OUT_VALID); else n_pass++;
        n_total++; if (bus_if.RMIN_OUT !== -8'sd7 || bus_if.RMAX_OUT !== 8'sd42) $display("FAIL hold_extremes got=%0d/%0d exp=42/-7", bus_if.RMAX_OUT, bus_if.RMIN_OUT); else n_pass++;
        set_in(1'b0, 1'b0, 2'b00, 8'sd0);
        tick;
        n_total++; if (bus_if.DATA_OUT !== 8'sd42) $display("FAIL hold_2 got=%0d exp=42", bus_if.DATA_OUT); else n_pass++;
    endtask

    task automatic test_sync_clr;
        init_run(8'sd0);
        set_in(1'b0, 1'b1, 2'b00, 8'sd10); tick;
        set_in(1'b0, 1'b0, 2'b00, 8'sd20); tick;
        bus_if.SYNC_CLR = 1'b1;
        set_in(1'b0, 1'b0, 2'b00, 8'sd99);
        tick;
        n_total++; if (state_dbg !== 2'd1) $display("FAIL clr_state got=%0d exp=1", state_dbg); else n_pass++;
        n_total++; if (bus_if.DATA_OUT !== 8'sd10 || bus_if.OUT_VALID !== 1'b1 || bus_if.RMAX_OUT !== 8'sd20) $display("FAIL clr_frozen got=%0d/%0b/%0d exp=10/1/20", bus_if.DATA_OUT, bus_if.OUT_VALID, bus_if.RMAX_OUT); else n_pass++;
        bus_if.SYNC_CLR = 1'b0;
        set_in(1'b0, 1'b0, 2'b00, -8'sd9);
        tick;
        n_total++; if (bus_if.RMAX_OUT !== -8'sd9 || bus_if.RMIN_OUT !== -8'sd9) $display("FAIL clr_load got=%0d/%0d exp=-9/-9", bus_if.RMAX_OUT, bus_if.RMIN_OUT); else n_pass++;
        n_total++; if (bus_if.DATA_OUT !== 8'sd0 || bus_if.OUT_VALID !== 1'b0) $display("FAIL clr_out got=%0d/%0b exp=0/0", bus_if.DATA_OUT, bus_if.OUT_VALID); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 2'b10, 8'sd0);
            tick;
            n_total++; if (bus_if.OUT_VALID !== (i == 4)) $display("FAIL clr_fill_%0d got=%0b exp=%0b", i, bus_if.OUT_VALID, (i == 4)); else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        init_run(8'sd0);
        set_in(1'b0, 1'b1, 2'b00, 8'sd50); tick;
        set_in(1'b0, 1'b0, 2'b00, 8'sd60); tick;
        n_total++; if (bus_if.DATA_OUT !== 8'sd50 || bus_if.OUT_VALID !== 1'b1) $display("FAIL arst_pre got=%0d/%0b exp=50/1", bus_if.DATA_OUT, bus_if.OUT_VALID); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus_if.DATA_OUT !== 8'sd0 || bus_if.OUT_VALID !== 1'b0) $display("FAIL arst_out got=%0d/%0b exp=0/0", bus_if.DATA_OUT, bus_if.OUT_VALID); else n_pass++;
        n_total++; if (bus_if.RMAX_OUT !== 8'sd0 || state_dbg !== 2'd0) $display("FAIL arst_state got=%0d/%0d exp=0/0", bus_if.RMAX_OUT, state_dbg); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b1;
        bus_if.SYNC_CLR = 1'b0;
        set_in(1'b0, 1'b0, 2'b00, 8'sd0);
        test_reset;
        test_delay;
        test_moving_avg;
        test_midpoint;
        test_two_point_diff;
        test_hold;
        test_sync_clr;
        test_async_reset;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
